// File: rtl/conv_encoder_ctrl.sv
`timescale 1ns/1ps
// conv_encoder_ctrl
// Frame sequencer for a K=8, rate-1/2 convolutional encoder. Message bits are
// accepted over a valid/ready stream and shifted into the encoder one at a
// time. After the last message bit, TAIL_LEN zero bits are shifted to flush
// the encoder register. Every shift produces one coded pair {n1,n2}, which is
// held in a one-deep output slot until the downstream consumes it.
module conv_encoder_ctrl #(
    parameter int TAIL_LEN = 8,     // zero bits shifted after the last message bit (1..255)
    parameter int MAX_BITS = 1024   // message bits per frame before forced truncation (2..65535)
) (
    input  logic        clk,
    input  logic        n_reset,

    // message bit input stream
    input  logic        in_valid_i,
    input  logic        in_bit_i,
    input  logic        in_last_i,
    output logic        in_ready_o,

    // encoder control and status
    output logic        enc_msg_o,
    output logic        enc_shift_o,
    input  logic        enc_n1_i,
    input  logic        enc_n2_i,
    input  logic        enc_nonzero_i,

    // coded symbol output stream
    output logic        out_valid_o,
    output logic [1:0]  out_sym_o,
    output logic        out_last_o,
    input  logic        out_ready_i,

    // frame status
    output logic        frame_done_o,
    output logic        trunc_err_o,
    output logic        flush_err_o,
    output logic [15:0] bit_count_o
);

    localparam logic [7:0]  TAIL_INIT = 8'(TAIL_LEN);
    localparam logic [15:0] MAX_CNT   = 16'(MAX_BITS);

    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,   // idle or mid-frame, accepting message bits
        ST_TAIL  = 2'd1,   // shifting the zero tail
        ST_DRAIN = 2'd2    // waiting for the final tail symbol to be consumed
    } state_t;

    state_t      state_q, state_d;

    logic        out_valid_q,  out_valid_d;
    logic        last_pend_q,  last_pend_d;
    logic [7:0]  tail_cnt_q,   tail_cnt_d;
    logic [15:0] bit_count_q,  bit_count_d;
    logic        trunc_err_q,  trunc_err_d;
    logic        flush_err_q,  flush_err_d;
    logic        frame_done_q, frame_done_d;

    // The output slot can take a new symbol if it is empty or being emptied
    // this cycle; a shift and a consumption may therefore coincide.
    logic        slot_free;
    logic        accept;
    logic [15:0] count_inc;
    logic        hit_max;
    logic        frame_end;
    logic        tail_shift;
    logic        tail_end;
    logic        drain_hs;

    assign slot_free  = !out_valid_q || out_ready_i;
    assign accept     = (state_q == ST_DATA) && in_valid_i && slot_free;
    assign count_inc  = bit_count_q + 16'd1;
    assign hit_max    = (count_inc == MAX_CNT);
    assign frame_end  = accept && (in_last_i || hit_max);
    assign tail_shift = (state_q == ST_TAIL) && slot_free;
    assign tail_end   = tail_shift && (tail_cnt_q == 8'd1);
    assign drain_hs   = (state_q == ST_DRAIN) && out_valid_q && out_ready_i;

    // State register: reset returns to DATA immediately.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DATA -> TAIL on the frame's final bit, TAIL -> DRAIN on
    // the last tail shift, DRAIN -> DATA once that last symbol is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DATA:  if (frame_end) state_d = ST_TAIL;
            ST_TAIL:  if (tail_end)  state_d = ST_DRAIN;
            ST_DRAIN: if (drain_hs)  state_d = ST_DATA;
            default:                 state_d = ST_DATA;
        endcase
    end

    // Output decode: message bits pass through in DATA, zeros are shifted in
    // TAIL, and nothing moves in DRAIN. Shifts only happen into a free slot.
    always_comb begin
        in_ready_o  = 1'b0;
        enc_shift_o = 1'b0;
        enc_msg_o   = 1'b0;
        case (state_q)
            ST_DATA: begin
                in_ready_o  = slot_free;
                enc_shift_o = accept;
                enc_msg_o   = accept && in_bit_i;
            end
            ST_TAIL: begin
                enc_shift_o = slot_free;
            end
            default: begin
                in_ready_o  = 1'b0;
            end
        endcase
    end

    // Datapath next-state: output slot occupancy, counters and sticky flags.
    always_comb begin
        // every shift fills the slot; otherwise a consumption empties it
        if (enc_shift_o) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        bit_count_d = bit_count_q;
        if (drain_hs) begin
            bit_count_d = 16'd0;
        end else if (accept) begin
            bit_count_d = count_inc;
        end

        tail_cnt_d = tail_cnt_q;
        if (frame_end) begin
            tail_cnt_d = TAIL_INIT;
        end else if (tail_shift) begin
            tail_cnt_d = tail_cnt_q - 8'd1;
        end

        // marks that the symbol now in the slot is the frame's final one
        last_pend_d = last_pend_q;
        if (tail_end) begin
            last_pend_d = 1'b1;
        end else if (drain_hs) begin
            last_pend_d = 1'b0;
        end

        // in_last on the MAX_BITS-th bit is a normal end, not a truncation
        trunc_err_d  = trunc_err_q || (accept && hit_max && !in_last_i);
        // the tail should have left the encoder register all-zero
        flush_err_d  = flush_err_q || (drain_hs && enc_nonzero_i);
        frame_done_d = drain_hs;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid_q  <= 1'b0;
            last_pend_q  <= 1'b0;
            tail_cnt_q   <= 8'd0;
            bit_count_q  <= 16'd0;
            trunc_err_q  <= 1'b0;
            flush_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            last_pend_q  <= last_pend_d;
            tail_cnt_q   <= tail_cnt_d;
            bit_count_q  <= bit_count_d;
            trunc_err_q  <= trunc_err_d;
            flush_err_q  <= flush_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // The encoder does not shift while a symbol is held, so its outputs are
    // the stable symbol value for as long as out_valid is high.
    assign out_sym_o    = {enc_n1_i, enc_n2_i};
    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_valid_q && last_pend_q;
    assign frame_done_o = frame_done_q;
    assign trunc_err_o  = trunc_err_q;
    assign flush_err_o  = flush_err_q;
    assign bit_count_o  = bit_count_q;

endmodule

// File: tb/tb_conv_encoder_ctrl.sv
`timescale 1ns/1ps
// Directed testbench for conv_encoder_ctrl. Three instances share the input
// stimulus: [0] default parameters, [1] MAX_BITS=4, [2] TAIL_LEN=7. Each has
// its own K=8 encoder model whose impulse response is 11,10,11,10,10,01,01,11.
module tb_conv_encoder_ctrl;

    localparam logic [7:0] G1 = 8'b1001_1111;
    localparam logic [7:0] G2 = 8'b1110_0101;

    logic clk       = 1'b0;
    logic n_reset   = 1'b0;
    logic in_valid  = 1'b0;
    logic in_bit    = 1'b0;
    logic in_last   = 1'b0;
    logic out_ready = 1'b1;

    always #5 clk = ~clk;

    wire [2:0]  in_ready_w, enc_msg_w, enc_shift_w, enc_n1_w, enc_n2_w, enc_nz_w;
    wire [2:0]  out_valid_w, out_last_w, frame_done_w, trunc_err_w, flush_err_w;
    wire [1:0]  out_sym_w   [3];
    wire [15:0] bit_count_w [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int TL = (gi == 2) ? 7 : 8;
            localparam int MB = (gi == 1) ? 4 : 1024;
            logic [7:0] enc_reg_q;

            // encoder model: newest bit in bit 0
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset)             enc_reg_q <= 8'd0;
                else if (enc_shift_w[gi]) enc_reg_q <= {enc_reg_q[6:0], enc_msg_w[gi]};
            end
            assign enc_n1_w[gi] = ^(enc_reg_q & G1);
            assign enc_n2_w[gi] = ^(enc_reg_q & G2);
            assign enc_nz_w[gi] = |enc_reg_q;

            conv_encoder_ctrl #(.TAIL_LEN(TL), .MAX_BITS(MB)) u_dut (
                .clk          (clk),
                .n_reset      (n_reset),
                .in_valid_i   (in_valid),
                .in_bit_i     (in_bit),
                .in_last_i    (in_last),
                .in_ready_o   (in_ready_w[gi]),
                .enc_msg_o    (enc_msg_w[gi]),
                .enc_shift_o  (enc_shift_w[gi]),
                .enc_n1_i     (enc_n1_w[gi]),
                .enc_n2_i     (enc_n2_w[gi]),
                .enc_nonzero_i(enc_nz_w[gi]),
                .out_valid_o  (out_valid_w[gi]),
                .out_sym_o    (out_sym_w[gi]),
                .out_last_o   (out_last_w[gi]),
                .out_ready_i  (out_ready),
                .frame_done_o (frame_done_w[gi]),
                .trunc_err_o  (trunc_err_w[gi]),
                .flush_err_o  (flush_err_w[gi]),
                .bit_count_o  (bit_count_w[gi])
            );
        end
    endgenerate

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] got_sym [$];
    logic       got_last[$];
    logic [1:0] exp_sym [$];
    int sent, acc_cyc, fv_cyc, fd_cyc, last_hs, shift_viol, max_bc;
    bit done;
    logic [3:0] rdy_pat = 4'b1001;   // out_ready sequence 1,0,0,1 repeating

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        n_reset  = 1'b0;
        @(posedge clk); #1;
        n_reset  = 1'b1;
        @(posedge clk); #1;
    endtask

    // Feed bits[0..nbits-1] to instance k and record every consumed symbol
    // until frame_done is seen (bounded by a cycle budget).
    task automatic run_frame(input int k, input int nbits, input logic [15:0] bits,
                             input bit use_last, input bit bp);
        int cyc;
        got_sym.delete(); got_last.delete();
        sent = 0; acc_cyc = -1; fv_cyc = -1; fd_cyc = -1; last_hs = -1;
        shift_viol = 0; max_bc = 0; done = 1'b0; cyc = 0;
        while (!done && cyc < 200) begin
            out_ready = bp ? rdy_pat[cyc % 4] : 1'b1;
            if (sent < nbits) begin
                in_valid = 1'b1;
                in_bit   = bits[sent];
                in_last  = use_last && (sent == nbits - 1);
            end else begin
                in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
            end
            #1;
            if (frame_done_w[k]) begin
                fd_cyc = cyc; done = 1'b1;
                in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
            end else begin
                if (in_valid && in_ready_w[k]) begin
                    if (acc_cyc < 0) acc_cyc = cyc;
                    sent++;
                end
                if (out_valid_w[k] && fv_cyc < 0) fv_cyc = cyc;
                if (out_valid_w[k] && out_ready) begin
                    got_sym.push_back(out_sym_w[k]);
                    got_last.push_back(out_last_w[k]);
                    last_hs = cyc;
                end
                if (out_valid_w[k] && !out_ready && enc_shift_w[k]) shift_viol++;
                if (int'(bit_count_w[k]) > max_bc) max_bc = int'(bit_count_w[k]);
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        chk($sformatf("frame_done_seen_k%0d", k), 32'(done), 32'd1);
        $display("frame inst=%0d accepted=%0d symbols=%0d accept_cyc=%0d done_cyc=%0d",
                 k, sent, got_sym.size(), acc_cyc, fd_cyc);
    endtask

    task automatic check_syms(input string tag);
        int n;
        n = exp_sym.size();
        chk({tag, "_count"}, 32'(got_sym.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_sym%0d", tag, i),
                (i < got_sym.size()) ? 32'(got_sym[i]) : 32'hxxxx_xxxx, 32'(exp_sym[i]));
            chk($sformatf("%s_last%0d", tag, i),
                (i < got_last.size()) ? 32'(got_last[i]) : 32'hxxxx_xxxx, 32'(i == n - 1));
        end
    endtask

    initial begin
        // ---- reset values (instance 0) ----
        n_reset = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready",   32'(in_ready_w[0]),   32'd1);
        chk("rst_enc_shift",  32'(enc_shift_w[0]),  32'd0);
        chk("rst_enc_msg",    32'(enc_msg_w[0]),    32'd0);
        chk("rst_out_valid",  32'(out_valid_w[0]),  32'd0);
        chk("rst_out_last",   32'(out_last_w[0]),   32'd0);
        chk("rst_frame_done", 32'(frame_done_w[0]), 32'd0);
        chk("rst_trunc_err",  32'(trunc_err_w[0]),  32'd0);
        chk("rst_flush_err",  32'(flush_err_w[0]),  32'd0);
        chk("rst_bit_count",  32'(bit_count_w[0]),  32'd0);
        chk("rst_out_sym",    32'(out_sym_w[0]),    32'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;

        // ---- single-bit frame ----
        run_frame(0, 1, 16'h0001, 1'b1, 1'b0);
        exp_sym = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
        check_syms("single");
        chk("single_latency",   32'(fv_cyc - acc_cyc), 32'd1);
        chk("single_gap",       32'(fd_cyc - acc_cyc), 32'd10);
        chk("single_fd_after",  32'(fd_cyc - last_hs), 32'd1);
        chk("single_max_count", 32'(max_bc),           32'd1);
        chk("single_flush_err", 32'(flush_err_w[0]),   32'd0);
        chk("single_count_clr", 32'(bit_count_w[0]),   32'd0);

        // ---- back-pressure: 1,0,1 with out_ready 1,0,0,1,... ----
        run_frame(0, 3, 16'b101, 1'b1, 1'b1);
        exp_sym = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00};
        check_syms("bp");
        chk("bp_no_shift_held", 32'(shift_viol),      32'd0);
        chk("bp_flush_err",     32'(flush_err_w[0]),  32'd0);

        // ---- back-to-back frames: 1,1 then 1 ----
        run_frame(0, 2, 16'b11, 1'b1, 1'b0);
        exp_sym = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00};
        check_syms("b2b_a");
        chk("b2b_a_max_count", 32'(max_bc),         32'd2);
        chk("b2b_a_count_clr", 32'(bit_count_w[0]), 32'd0);
        run_frame(0, 1, 16'h0001, 1'b1, 1'b0);
        exp_sym = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
        check_syms("b2b_b");
        chk("b2b_trunc_err", 32'(trunc_err_w[0]), 32'd0);

        // ---- MAX_BITS=4 with in_last on the 4th bit: normal end ----
        pulse_reset();
        run_frame(1, 4, 16'b1011, 1'b1, 1'b0);
        exp_sym = '{2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00,
                    2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
        check_syms("maxlast");
        chk("maxlast_trunc_err", 32'(trunc_err_w[1]), 32'd0);

        // ---- truncation: 6 bits, no in_last, MAX_BITS=4 ----
        run_frame(1, 6, 16'b011011, 1'b0, 1'b0);
        check_syms("trunc");
        chk("trunc_accepted",  32'(sent),           32'd4);
        chk("trunc_max_count", 32'(max_bc),         32'd4);
        chk("trunc_err_set",   32'(trunc_err_w[1]), 32'd1);
        chk("trunc_flush_err", 32'(flush_err_w[1]), 32'd0);
        // the 5th bit opens the next frame
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
        #1;
        chk("trunc_next_ready", 32'(in_ready_w[1]),  32'd1);
        chk("trunc_next_shift", 32'(enc_shift_w[1]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_bit = 1'b0;
        chk("trunc_next_count", 32'(bit_count_w[1]), 32'd1);
        chk("trunc_next_valid", 32'(out_valid_w[1]), 32'd1);
        chk("trunc_next_sym",   32'(out_sym_w[1]),   32'd3);

        // ---- short tail: TAIL_LEN=7 leaves the register non-zero ----
        pulse_reset();
        run_frame(2, 1, 16'h0001, 1'b1, 1'b0);
        exp_sym = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
        check_syms("short");
        chk("short_gap",       32'(fd_cyc - acc_cyc), 32'd9);
        chk("short_flush_err", 32'(flush_err_w[2]),   32'd1);

        // ---- reset while in the tail ----
        pulse_reset();
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_no_fd%0d", i), 32'(frame_done_w[0]), 32'd0);
            @(posedge clk); #1;
        end
        chk("midrst_busy_valid", 32'(out_valid_w[0]), 32'd1);
        chk("midrst_busy_count", 32'(bit_count_w[0]), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("midrst_out_valid",  32'(out_valid_w[0]),  32'd0);
        chk("midrst_in_ready",   32'(in_ready_w[0]),   32'd1);
        chk("midrst_enc_shift",  32'(enc_shift_w[0]),  32'd0);
        chk("midrst_out_last",   32'(out_last_w[0]),   32'd0);
        chk("midrst_frame_done", 32'(frame_done_w[0]), 32'd0);
        chk("midrst_bit_count",  32'(bit_count_w[0]),  32'd0);
        chk("midrst_out_sym",    32'(out_sym_w[0]),    32'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 1, 16'h0001, 1'b1, 1'b0);
        exp_sym = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
        check_syms("after_rst");
        chk("after_rst_flush", 32'(flush_err_w[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
